// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with occupancy count,
// threshold flags, sticky error flags and a synchronous flush.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads.
// Ports:
//   clk, rst (async active-low), clr (sync flush)
//   wr_en, input_data  : write side
//   rd_en              : read request (pop in FWFT mode)
//   output_data, out_valid : read side
//   empty, full, almost_empty, almost_full, count : status
//   overflow, underflow : sticky error flags
module fifo_param #(
   parameter int FIFO_SIZE = 8,
   parameter int DATA_SIZE = 24,
   parameter int AFULL_TH  = FIFO_SIZE - 1,
   parameter int AEMPTY_TH = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic [DATA_SIZE-1:0]         input_data,
   input  logic                         rd_en,
   output logic [DATA_SIZE-1:0]         output_data,
   output logic                         out_valid,
   output logic                         empty,
   output logic                         full,
   output logic                         almost_empty,
   output logic                         almost_full,
   output logic [$clog2(FIFO_SIZE):0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int ADDR_W = $clog2(FIFO_SIZE);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(FIFO_SIZE);
   localparam logic [ADDR_W:0]   AF_CNT   = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0]   AE_CNT   = (ADDR_W+1)'(AEMPTY_TH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [DATA_SIZE-1:0] mem [FIFO_SIZE];
   logic [ADDR_W-1:0]    wr_ptr;
   logic [ADDR_W-1:0]    rd_ptr;
   logic                 rd_acc;
   logic                 wr_acc;

   // Status is decoded from the registered count only, so no request
   // input has a combinational path to any flag.
   assign empty        = (count == '0);
   assign full         = (count == FULL_CNT);
   assign almost_empty = (count <= AE_CNT);
   assign almost_full  = (count >= AF_CNT);

   // A full FIFO may still take a write when a read frees a slot in
   // the same cycle; an empty FIFO never bypasses write data to a read.
   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_acc);

   always_ff @(posedge clk) begin
      if (wr_acc && !clr) begin
         mem[wr_ptr] <= input_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (wr_en && !wr_acc) begin
            overflow <= 1'b1;
         end
         if (rd_en && !rd_acc) begin
            underflow <= 1'b1;
         end
      end
   end

`ifdef FIFO_FWFT_EN
   // Head entry is presented directly; zero is shown while empty.
   assign output_data = empty ? '0 : mem[rd_ptr];
   assign out_valid   = ~empty;
`else
   logic [DATA_SIZE-1:0] data_q;
   logic                 valid_q;

   // Data register holds its last value across idle cycles and flush;
   // only the valid pulse is cleared by a flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (clr) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= rd_acc;
         if (rd_acc) begin
            data_q <= mem[rd_ptr];
         end
      end
   end

   assign output_data = data_q;
   assign out_valid   = valid_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param
// (FIFO_SIZE=8, DATA_SIZE=24); covers both read modes via FIFO_FWFT_EN.
module tb_fifo_param;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        wr_en;
   logic [23:0] input_data;
   logic        rd_en;
   logic [23:0] output_data;
   logic        out_valid;
   logic        empty;
   logic        full;
   logic        almost_empty;
   logic        almost_full;
   logic [3:0]  count;
   logic        overflow;
   logic        underflow;

   int checks;
   int errors;

   fifo_param #(
      .FIFO_SIZE(8),
      .DATA_SIZE(24)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .wr_en(wr_en),
      .input_data(input_data),
      .rd_en(rd_en),
      .output_data(output_data),
      .out_valid(out_valid),
      .empty(empty),
      .full(full),
      .almost_empty(almost_empty),
      .almost_full(almost_full),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge with the given requests; returns 1 ns after the edge.
   task automatic cyc(input logic w, input logic r, input logic [23:0] d);
      wr_en      = w;
      rd_en      = r;
      input_data = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #3;
      checks++;
      if (count !== 4'd0) begin
         errors++;
         $display("FAIL reset_count got %0d exp 0", count);
      end
      checks++;
      if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
         errors++;
         $display("FAIL reset_flags got %b exp 1010",
                  {empty, full, almost_empty, almost_full});
      end
      checks++;
      if ({overflow, underflow, out_valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_err_valid got %b exp 000",
                  {overflow, underflow, out_valid});
      end
      checks++;
      if (output_data !== 24'd0) begin
         errors++;
         $display("FAIL reset_data got %0d exp 0", output_data);
      end
      #9;
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 24'(100 + i));
         checks++;
         if (count !== 4'(i + 1)) begin
            errors++;
            $display("FAIL fill_count got %0d exp %0d", count, i + 1);
         end
         checks++;
         if (almost_full !== (i + 1 >= 7)) begin
            errors++;
            $display("FAIL fill_afull at %0d got %b exp %b",
                     i + 1, almost_full, (i + 1 >= 7));
         end
         checks++;
         if (almost_empty !== (i + 1 <= 1)) begin
            errors++;
            $display("FAIL fill_aempty at %0d got %b exp %b",
                     i + 1, almost_empty, (i + 1 <= 1));
         end
      end
      checks++;
      if (full !== 1'b1) begin
         errors++;
         $display("FAIL fill_full got %b exp 1", full);
      end
      cyc(1'b1, 1'b0, 24'd99);
      checks++;
      if (overflow !== 1'b1 || count !== 4'd8) begin
         errors++;
         $display("FAIL overflow got ovf=%b cnt=%0d exp ovf=1 cnt=8",
                  overflow, count);
      end
   endtask

   task automatic test_full_rw;
`ifdef FIFO_FWFT_EN
      checks++;
      if (output_data !== 24'd100 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_rw_head got %0d/%b exp 100/1",
                  output_data, out_valid);
      end
      cyc(1'b1, 1'b1, 24'd150);
`else
      cyc(1'b1, 1'b1, 24'd150);
      checks++;
      if (output_data !== 24'd100 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_rw_data got %0d/%b exp 100/1",
                  output_data, out_valid);
      end
`endif
      checks++;
      if (count !== 4'd8 || full !== 1'b1) begin
         errors++;
         $display("FAIL full_rw_count got %0d/%b exp 8/1", count, full);
      end
   endtask

   task automatic test_drain;
      logic [23:0] exp_d;
      for (int i = 0; i < 8; i++) begin
         exp_d = (i == 7) ? 24'd150 : 24'(101 + i);
`ifdef FIFO_FWFT_EN
         checks++;
         if (output_data !== exp_d || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_head %0d got %0d/%b exp %0d/1",
                     i, output_data, out_valid, exp_d);
         end
         cyc(1'b0, 1'b1, 24'd0);
`else
         cyc(1'b0, 1'b1, 24'd0);
         checks++;
         if (output_data !== exp_d || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_data %0d got %0d/%b exp %0d/1",
                     i, output_data, out_valid, exp_d);
         end
`endif
      end
      checks++;
      if (empty !== 1'b1 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty got %b/%b exp 1/0", empty, underflow);
      end
      cyc(1'b0, 1'b1, 24'd0);
      checks++;
      if (underflow !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL underflow got unf=%b vld=%b exp 1/0",
                  underflow, out_valid);
      end
   endtask

   task automatic test_empty_rw;
      cyc(1'b1, 1'b1, 24'd170);
`ifdef FIFO_FWFT_EN
      checks++;
      if (out_valid !== 1'b1 || output_data !== 24'd170) begin
         errors++;
         $display("FAIL empty_rw_head got %0d/%b exp 170/1",
                  output_data, out_valid);
      end
`else
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL empty_rw_valid got %b exp 0", out_valid);
      end
`endif
      checks++;
      if (count !== 4'd1 || underflow !== 1'b1) begin
         errors++;
         $display("FAIL empty_rw_count got %0d/%b exp 1/1",
                  count, underflow);
      end
      cyc(1'b0, 1'b1, 24'd0);
`ifndef FIFO_FWFT_EN
      checks++;
      if (output_data !== 24'd170 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL empty_rw_read got %0d/%b exp 170/1",
                  output_data, out_valid);
      end
`endif
      checks++;
      if (count !== 4'd0) begin
         errors++;
         $display("FAIL empty_rw_drain got %0d exp 0", count);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, 24'(200 + i));
         checks++;
         if (count !== 4'd1) begin
            errors++;
            $display("FAIL b2b_count1 %0d got %0d exp 1", i, count);
         end
`ifdef FIFO_FWFT_EN
         checks++;
         if (output_data !== 24'(200 + i)) begin
            errors++;
            $display("FAIL b2b_head %0d got %0d exp %0d",
                     i, output_data, 200 + i);
         end
         cyc(1'b0, 1'b1, 24'd0);
`else
         cyc(1'b0, 1'b1, 24'd0);
         checks++;
         if (output_data !== 24'(200 + i)) begin
            errors++;
            $display("FAIL b2b_data %0d got %0d exp %0d",
                     i, output_data, 200 + i);
         end
`endif
         checks++;
         if (count !== 4'd0) begin
            errors++;
            $display("FAIL b2b_count0 %0d got %0d exp 0", i, count);
         end
      end
   endtask

   task automatic test_clr;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 24'(300 + i));
      end
      cyc(1'b0, 1'b1, 24'd0);
      checks++;
      if (count !== 4'd3) begin
         errors++;
         $display("FAIL clr_pre got %0d exp 3", count);
      end
      clr = 1'b1;
      cyc(1'b1, 1'b1, 24'd400);
      clr = 1'b0;
      checks++;
      if (count !== 4'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL clr_count got %0d/%b exp 0/1", count, empty);
      end
      checks++;
      if ({overflow, underflow, out_valid} !== 3'b000) begin
         errors++;
         $display("FAIL clr_flags got %b exp 000",
                  {overflow, underflow, out_valid});
      end
`ifndef FIFO_FWFT_EN
      checks++;
      if (output_data !== 24'd300) begin
         errors++;
         $display("FAIL clr_hold got %0d exp 300", output_data);
      end
`endif
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 24'(50 + i));
      end
      cyc(1'b1, 1'b1, 24'd60);
      checks++;
      if (count !== 4'd5) begin
         errors++;
         $display("FAIL arst_pre got %0d exp 5", count);
      end
      wr_en      = 1'b1;
      input_data = 24'd77;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
         errors++;
         $display("FAIL arst_count got %0d/%b/%b exp 0/1/0",
                  count, empty, full);
      end
      checks++;
      if ({out_valid, overflow, underflow} !== 3'b000
          || output_data !== 24'd0) begin
         errors++;
         $display("FAIL arst_out got %b data %0d exp 000 data 0",
                  {out_valid, overflow, underflow}, output_data);
      end
      @(posedge clk);
      #3;
      wr_en = 1'b0;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (count !== 4'd0) begin
         errors++;
         $display("FAIL arst_hold got %0d exp 0", count);
      end
      cyc(1'b1, 1'b0, 24'd42);
      checks++;
      if (count !== 4'd1) begin
         errors++;
         $display("FAIL arst_wr got %0d exp 1", count);
      end
`ifdef FIFO_FWFT_EN
      checks++;
      if (output_data !== 24'd42 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL arst_rd got %0d/%b exp 42/1",
                  output_data, out_valid);
      end
      cyc(1'b0, 1'b1, 24'd0);
`else
      cyc(1'b0, 1'b1, 24'd0);
      checks++;
      if (output_data !== 24'd42 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL arst_rd got %0d/%b exp 42/1",
                  output_data, out_valid);
      end
`endif
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      clr        = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      input_data = '0;
      test_reset();
      test_fill();
      test_full_rw();
      test_drain();
      test_empty_rw();
      test_back_to_back();
      test_clr();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
